// File: rtl/l2p_pkg.sv
// Shared encodings and sizing helper for the multi-channel level-to-pulse converter.
package l2p_pkg;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PULSE = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  function automatic int cnt_width(input int pulse_width, input int holdoff);
    int m;
    int w;
    m = (pulse_width > holdoff) ? pulse_width : holdoff;
    w = $clog2(m + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/l2p_channel.sv
// One channel: optional 2-flop synchronizer (L2P_SYNC_EN), edge detect,
// IDLE/PULSE/HOLD sequencer and sticky overrun flag.
module l2p_channel
  import l2p_pkg::*;
#(
  parameter int PULSE_WIDTH = 1,
  parameter int HOLDOFF     = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       level_in,
  input  logic [1:0] mode,
  input  logic       clear_ovr,
  output logic       pulse_out,
  output logic       busy,
  output logic       overrun
);

  localparam int CW = cnt_width(PULSE_WIDTH, HOLDOFF);
  localparam logic [CW-1:0] PW_LD = CW'(PULSE_WIDTH - 1);
  localparam logic [CW-1:0] HO_LD = CW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
  localparam bit NO_HOLD = (HOLDOFF == 0);

  logic          lvl;
  logic          lvl_prev;
  logic [1:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          rise, fall, qual, rearm, accept;

`ifdef L2P_SYNC_EN
  logic lvl_p0, lvl_p1;

  // synchronizer stages
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lvl_p0 <= 1'b0;
      lvl_p1 <= 1'b0;
    end else begin
      lvl_p0 <= level_in;
      lvl_p1 <= lvl_p0;
    end
  end
  assign lvl = lvl_p1;
`else
  assign lvl = level_in;
`endif

  always_comb begin
    rise = lvl & ~lvl_prev;
    fall = ~lvl & lvl_prev;
    case (mode)
      MODE_RISE: qual = rise;
      MODE_FALL: qual = fall;
      MODE_BOTH: qual = rise | fall;
      default:   qual = 1'b0;
    endcase
  end

  // The last busy cycle doubles as the re-arm point, so an edge landing there is taken.
  assign rearm  = (cnt == '0) && ((state == HOLD) || (state == PULSE && NO_HOLD));
  assign accept = qual && ((state == IDLE) || rearm);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IDLE: begin
        if (qual) begin
          state_nx = PULSE;
          cnt_nx   = PW_LD;
        end
      end
      PULSE: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else if (accept) begin
          cnt_nx = PW_LD;
        end else if (!NO_HOLD) begin
          state_nx = HOLD;
          cnt_nx   = HO_LD;
        end else begin
          state_nx = IDLE;
        end
      end
      HOLD: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CW'(1);
        end else if (accept) begin
          state_nx = PULSE;
          cnt_nx   = PW_LD;
        end else begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // state, edge history and overrun registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      lvl_prev <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      lvl_prev <= lvl;
      overrun  <= (qual && busy && !accept) | (overrun & ~clear_ovr);
    end
  end

  assign pulse_out = (state == PULSE);
  assign busy      = (state != IDLE);

endmodule

// File: rtl/multi_edge_pulse_gen.sv
// Multi-channel edge-to-pulse converter; CHANNELS independent l2p_channel slices.
// Define L2P_SYNC_EN to add a 2-flop synchronizer on every level input.
module multi_edge_pulse_gen
  import l2p_pkg::*;
#(
  parameter int CHANNELS    = 4,
  parameter int PULSE_WIDTH = 1,
  parameter int HOLDOFF     = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [CHANNELS-1:0]   level_in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clear_ovr,
  output logic [CHANNELS-1:0]   pulse_out,
  output logic [CHANNELS-1:0]   busy,
  output logic [CHANNELS-1:0]   overrun
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    l2p_channel #(
      .PULSE_WIDTH (PULSE_WIDTH),
      .HOLDOFF     (HOLDOFF)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .level_in  (level_in[i]),
      .mode      (mode[2*i+1:2*i]),
      .clear_ovr (clear_ovr[i]),
      .pulse_out (pulse_out[i]),
      .busy      (busy[i]),
      .overrun   (overrun[i])
    );
  end

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Directed bench for multi_edge_pulse_gen: one instance with PULSE_WIDTH=1/HOLDOFF=0,
// one with PULSE_WIDTH=3/HOLDOFF=2.
module tb_multi_edge_pulse_gen;

`ifdef L2P_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] lvl_a, clr_a, pulse_a, busy_a, ovr_a;
  logic [7:0] mode_a;
  logic [3:0] lvl_b, clr_b, pulse_b, busy_b, ovr_b;
  logic [7:0] mode_b;

  int checks = 0;
  int errors = 0;

  multi_edge_pulse_gen #(.CHANNELS(4), .PULSE_WIDTH(1), .HOLDOFF(0)) dut_a (
    .clk       (clk),
    .reset     (rst_n),
    .level_in  (lvl_a),
    .mode      (mode_a),
    .clear_ovr (clr_a),
    .pulse_out (pulse_a),
    .busy      (busy_a),
    .overrun   (ovr_a)
  );

  multi_edge_pulse_gen #(.CHANNELS(4), .PULSE_WIDTH(3), .HOLDOFF(2)) dut_b (
    .clk       (clk),
    .reset     (rst_n),
    .level_in  (lvl_b),
    .mode      (mode_b),
    .clear_ovr (clr_b),
    .pulse_out (pulse_b),
    .busy      (busy_b),
    .overrun   (ovr_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // one sampling edge plus any synchronizer delay
  task automatic settle();
    step();
    repeat (SYNC_LAT) step();
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    lvl_a  = 4'b0000;
    clr_a  = 4'b0000;
    mode_a = 8'b01_01_01_01;
    lvl_b  = 4'b0000;
    clr_b  = 4'b0000;
    mode_b = 8'b00_10_11_00;

    #12;
    chk("rst_pulse_a", pulse_a, 4'b0000);
    chk("rst_busy_a",  busy_a,  4'b0000);
    chk("rst_ovr_a",   ovr_a,   4'b0000);
    chk("rst_pulse_b", pulse_b, 4'b0000);
    chk("rst_busy_b",  busy_b,  4'b0000);

    step();
    rst_n = 1'b1;
    step();
    step();
    chk("idle_pulse_a", pulse_a, 4'b0000);

    // single-cycle pulse on ch0 of dut_a
    lvl_a = 4'b0001;
    settle();
    chk("a0_pulse_on",  pulse_a, 4'b0001);
    chk("a0_busy_on",   busy_a,  4'b0001);
    step();
    chk("a0_pulse_off", pulse_a, 4'b0000);
    chk("a0_busy_off",  busy_a,  4'b0000);
    lvl_a = 4'b0000;
    settle();
    step();
    chk("a0_fall_ignored", busy_a, 4'b0000);

    // ch1 of dut_b, both edges, 3-cycle pulse + 2-cycle holdoff
    lvl_b = 4'b0010;
    settle();
    chk("b1_pulse_c1", pulse_b, 4'b0010);
    lvl_b = 4'b0000;
    step();
    chk("b1_pulse_c2", pulse_b, 4'b0010);
    step();
    chk("b1_pulse_c3", pulse_b, 4'b0010);
    step();
    chk("b1_hold_pulse", pulse_b, 4'b0000);
    chk("b1_hold_busy",  busy_b,  4'b0010);
    chk("b1_overrun",    ovr_b,   4'b0010);
    step();
    chk("b1_hold_last",  busy_b,  4'b0010);
    lvl_b = 4'b0010;
    settle();
    chk("b1_rearm_pulse", pulse_b, 4'b0010);
    chk("b1_ovr_sticky",  ovr_b,   4'b0010);

    lvl_b = 4'b0000;
    repeat (SYNC_LAT) step();
    clr_b = 4'b0010;
    step();
    chk("b1_set_beats_clear", ovr_b, 4'b0010);
    clr_b = 4'b0000;
    step();
    clr_b = 4'b0010;
    step();
    chk("b1_clear", ovr_b, 4'b0000);
    clr_b = 4'b0000;
    repeat (6) step();
    chk("b_idle", busy_b, 4'b0000);

    // ch2 of dut_b, falling-only, then disabled mid-pulse
    lvl_b = 4'b0100;
    settle();
    chk("b2_rise_ignored", pulse_b, 4'b0000);
    chk("b2_rise_no_busy", busy_b,  4'b0000);
    lvl_b = 4'b0000;
    settle();
    chk("b2_fall_pulse", pulse_b, 4'b0100);
    mode_b[5:4] = 2'b00;
    step();
    chk("b2_off_c2", pulse_b, 4'b0100);
    step();
    chk("b2_off_c3", pulse_b, 4'b0100);
    step();
    chk("b2_off_hold_pulse", pulse_b, 4'b0000);
    chk("b2_off_hold_busy",  busy_b,  4'b0100);
    repeat (2) step();
    chk("b2_off_idle", busy_b, 4'b0000);
    lvl_b = 4'b0100;
    settle();
    step();
    lvl_b = 4'b0000;
    settle();
    chk("b2_off_no_busy", busy_b, 4'b0000);
    chk("b2_off_no_ovr",  ovr_b,  4'b0000);

    // level already high at reset release on ch3 of dut_a
    rst_n = 1'b0;
    lvl_a = 4'b1000;
    #1;
    chk("a3_in_reset", pulse_a, 4'b0000);
    step();
    rst_n = 1'b1;
    settle();
    chk("a3_release_pulse", pulse_a, 4'b1000);
    step();
    chk("a3_single_pulse", pulse_a, 4'b0000);

    // asynchronous reset in the middle of a pulse
    lvl_b = 4'b0010;
    settle();
    chk("b1_pre_reset", pulse_b, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    chk("b1_async_pulse", pulse_b, 4'b0000);
    chk("b1_async_busy",  busy_b,  4'b0000);
    step();
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_edge_pulse_gen.md
Name: multi_edge_pulse_gen

Overview:
- Parametrised, multi-channel successor to the single-bit level-to-pulse converter.
- Each channel detects a selectable edge (rising, falling, both, or none) on a level input.
- On a detected edge, the channel emits a registered pulse of PULSE_WIDTH cycles, then holds off for HOLDOFF cycles before re-arming.
- Edges that arrive while a channel is busy are flagged in a sticky overrun bit. Sits between slow level sources (buttons, status lines) and single-cycle event consumers.

Parameters:
- CHANNELS, 4, number of independent channels (>=1).
- PULSE_WIDTH, 1, output pulse length in clk cycles (>=1).
- HOLDOFF, 0, dead cycles after each pulse before the channel re-arms (>=0).

Ports:
- clk  input  1  single system clock, all logic on posedge.
- reset  input  1  asynchronous, active-low reset.
- level_in  input  CHANNELS  per-channel level inputs, synchronous to clk unless L2P_SYNC_EN is defined.
- mode  input  2*CHANNELS  per-channel edge select; bits [2i+1:2i] for channel i.
- clear_ovr  input  CHANNELS  per-channel clear of the sticky overrun flag.
- pulse_out  output  CHANNELS  registered pulse per channel.
- busy  output  CHANNELS  high while the channel is in PULSE or HOLD.
- overrun  output  CHANNELS  sticky: a qualifying edge occurred while busy.

Behaviour:
- Reset (async assert, sync release): state=IDLE, prev level=0, counter=0, pulse_out=0, busy=0, overrun=0.
- Mode encoding: 00 disabled, 01 rising, 10 falling, 11 both.
- Edge detect: each channel has a prev register that updates every cycle, in every state and mode.
  - rise = lvl & ~prev; fall = ~lvl & prev.
  - A qualifying edge is the edge matching the mode sampled in the same cycle.
- Because prev resets to 0, a level already high at reset release counts as a rising edge on the first clock.
- FSM per channel, states IDLE, PULSE, HOLD:
  - IDLE: on a qualifying edge, go to PULSE and load counter = PULSE_WIDTH-1.
  - PULSE: while counter != 0, decrement. At 0, go to HOLD with counter = HOLDOFF-1 if HOLDOFF>0; otherwise go to IDLE.
  - HOLD: while counter != 0, decrement. At 0, go to IDLE.
- Outputs are registered, Moore, and decoded from the state register: pulse_out = (state==PULSE); busy = (state!=IDLE).
- Latency: an edge sampled at posedge N drives pulse_out high from posedge N+1 through posedge N+PULSE_WIDTH.
- A channel re-arms at the earliest on posedge N+PULSE_WIDTH+HOLDOFF. An edge sampled on that cycle is accepted.
- Overrun: a qualifying edge sampled while the state is PULSE or HOLD is ignored and sets overrun. If set and clear_ovr hit the same cycle, set wins.
- Mode change mid-pulse: the in-flight pulse/holdoff completes unchanged. The new mode applies to edges sampled afterwards. Mode 00 never starts a pulse and never sets overrun.
- Channels are fully independent; simultaneous edges on different channels are all serviced in parallel.
- Counter width = clog2(max(PULSE_WIDTH,HOLDOFF)+1), minimum 1 bit; no wrap occurs under the stated parameter limits.
- Reset asserted mid-pulse: pulse_out drops immediately (asynchronous); all state returns to reset values.

Optional Feature:
- Macro: L2P_SYNC_EN.
- Defined: each level_in bit passes through a 2-flop synchronizer (reset to 0) before edge detect. Adds 2 cycles of latency, so an edge at the pin on posedge N gives pulse_out high from N+3.
- Undefined: level_in feeds edge detect directly, with the latency stated above.

Decomposition:
- Shared package l2p_pkg: state encodings (IDLE, PULSE, HOLD), mode encodings (MODE_OFF, MODE_RISE, MODE_FALL, MODE_BOTH), and a counter-width function.
- One natural sub-module, l2p_channel: the per-channel synchronizer, edge detect, FSM, counter and overrun logic. The top instantiates it CHANNELS times via generate.

Test Plan:
- Reset with level_in=0, mode=01, PULSE_WIDTH=1: raise ch0 at cycle 5 -> pulse_out[0] high exactly in cycle 6, busy[0] high only in cycle 6.
- PULSE_WIDTH=3, HOLDOFF=2, mode=11: toggle ch1 at cycle 10, then again at cycle 12 -> pulse_out[1] high in cycles 11-13, second edge ignored, overrun[1]=1.
- Same setup: next edge at cycle 15 -> accepted, pulse in cycles 16-18, overrun unchanged until clear_ovr[1] is pulsed.
- Simultaneous clear_ovr[1] and a new busy-time edge -> overrun stays 1.
- mode=10 on ch2: a 0->1 transition gives no pulse; the following 1->0 gives a pulse. Switching mode to 00 mid-pulse -> the current pulse completes and later edges produce nothing.
- Hold level_in[3]=1 through reset release with mode=01 -> one pulse on the first cycle after release. Asserting reset mid-pulse -> pulse_out clears immediately.
- With L2P_SYNC_EN defined, repeat the first scenario -> pulse in cycle 8.
